// File: rtl/iddr_deser_pkg.sv
// Shared types and constants for the IDDR pair deserializer.
package iddr_deser_pkg;

  // Alignment FSM states
  typedef enum logic [2:0] {
    ST_BYPASS,
    ST_HUNT,
    ST_BLANK,
    ST_CHECK,
    ST_LOCKED
  } state_e;

  // Q1 is the earlier serial bit of each IDDR pair (SAME_EDGE_PIPELINED)
  localparam bit Q1_FIRST = 1'b1;
  localparam int PAIR_W   = 2;

  // Slips tried without a pattern match before flagging an alignment error
  function automatic int slip_limit(input int word_w);
    return 2 * word_w;
  endfunction

endpackage

// File: rtl/iddr_deser_fifo.sv
// Small synchronous FIFO; storage is registered and the head entry is
// presented directly, so a pushed word is visible the cycle after the push.
module iddr_deser_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wr_q, rd_q;
  logic [AW:0]             cnt_q;
  logic                    full, do_pop, do_push;

  assign do_pop  = i_pop && (cnt_q != '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_push = i_push && (!full || do_pop);
  assign o_drop  = i_push && !do_push;
  assign o_valid = (cnt_q != '0);
  assign o_data  = o_valid ? mem_q[rd_q] : '0;

  // Storage, pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= i_data;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/iddr_deser.sv
// IDDR pair deserializer: assembles Q1/Q2 pairs into words, aligns the
// word boundary by bitslip (manual or trained), and buffers words in a FIFO.
module iddr_deser
  import iddr_deser_pkg::*;
#(
  parameter int                WORD_W        = 8,
  parameter int                FIFO_DEPTH    = 4,
  parameter logic [WORD_W-1:0] ALIGN_PATTERN = WORD_W'(8'hA5),
  parameter int                LOCK_COUNT    = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ce,
  input  logic              i_q1,
  input  logic              i_q2,
  input  logic              i_align_en,
  input  logic              i_bitslip,
  input  logic              i_ready,
  output logic [WORD_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_locked,
  output logic              o_align_err,
  output logic              o_overflow
);

  localparam int CW       = $clog2(WORD_W + 2);
  localparam int SLIP_LIM = slip_limit(WORD_W);
  localparam int SW       = $clog2(SLIP_LIM + 1);
  localparam int MW       = $clog2(LOCK_COUNT + 1);

  // Accumulator holds up to WORD_W+1 bits; the newest bit is at the LSB
  logic [WORD_W:0]       acc_q, acc_d, acc_n;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_n;
  logic [PAIR_W-1:0]     pair;
  logic                  late_bit;
  logic                  emit;
  logic [WORD_W-1:0]     word;
  logic                  slip_q, slip_d, slip_req;
  state_e                st_q, st_d;
  logic [MW-1:0]         mcnt_q, mcnt_d;
  logic [SW-1:0]         scnt_q, scnt_d;
  logic                  err_q, err_d;
  logic                  ovf_q;
  logic                  push, drop, match;

  assign pair     = Q1_FIRST ? {i_q1, i_q2} : {i_q2, i_q1};
  assign late_bit = Q1_FIRST ? i_q2 : i_q1;
  assign match    = (word == ALIGN_PATTERN);

  // Bit accumulation and word extraction (oldest WORD_W bits form the word)
  always_comb begin
    acc_n = acc_q;
    cnt_n = cnt_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    emit  = 1'b0;
    word  = '0;
    if (i_ce) begin
      if (slip_q) begin
        // Slip: the earlier bit of this pair is dropped
        acc_n = {acc_q[WORD_W-1:0], late_bit};
        cnt_n = cnt_q + CW'(1);
      end else begin
        acc_n = {acc_q[WORD_W-2:0], pair};
        cnt_n = cnt_q + CW'(PAIR_W);
      end
      acc_d = acc_n;
      cnt_d = cnt_n;
      if (cnt_n >= CW'(WORD_W)) begin
        emit  = 1'b1;
        // One leftover bit stays below the word when count overshoots
        word  = (cnt_n == CW'(WORD_W + 1)) ? acc_n[WORD_W:1] : acc_n[WORD_W-1:0];
        cnt_d = cnt_n - CW'(WORD_W);
      end
    end
  end

  // Alignment FSM next state, push decision and slip requests
  always_comb begin
    st_d     = st_q;
    mcnt_d   = mcnt_q;
    scnt_d   = scnt_q;
    err_d    = 1'b0;
    slip_req = 1'b0;
    push     = 1'b0;
    case (st_q)
      ST_BYPASS: begin
        push     = emit;
        slip_req = i_bitslip;
      end
      ST_HUNT: if (emit) begin
        if (match) begin
          mcnt_d = MW'(1);
          st_d   = (LOCK_COUNT <= 1) ? ST_LOCKED : ST_CHECK;
        end else begin
          slip_req = 1'b1;
          st_d     = ST_BLANK;
          if (scnt_q == SW'(SLIP_LIM - 1)) begin
            err_d  = 1'b1;
            scnt_d = '0;
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end
      end
      // The first word after a slip mixes bits from both sides of it
      ST_BLANK: if (emit) st_d = ST_HUNT;
      ST_CHECK: if (emit) begin
        if (match) begin
          mcnt_d = mcnt_q + MW'(1);
          if (mcnt_q == MW'(LOCK_COUNT - 1)) st_d = ST_LOCKED;
        end else begin
          st_d = ST_HUNT;
        end
      end
      ST_LOCKED: push = emit;
      default:   st_d = ST_BYPASS;
    endcase
    // Mode changes override any data-driven transition
    if (!i_align_en) begin
      st_d = ST_BYPASS;
    end else if (st_q == ST_BYPASS) begin
      st_d   = ST_HUNT;
      scnt_d = '0;
    end
  end

  // Slip pending: consumed by the next valid pair; new requests ignored while set
  always_comb begin
    slip_d = slip_q;
    if (i_ce && slip_q) slip_d = 1'b0;
    else if (slip_req)  slip_d = 1'b1;
  end

  // State registers; reset lands in BYPASS and moves to HUNT on the first
  // edge if alignment is enabled, so no reset value depends on an input
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      slip_q <= 1'b0;
      st_q   <= ST_BYPASS;
      mcnt_q <= '0;
      scnt_q <= '0;
      err_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      slip_q <= slip_d;
      st_q   <= st_d;
      mcnt_q <= mcnt_d;
      scnt_q <= scnt_d;
      err_q  <= err_d;
      ovf_q  <= ovf_q | drop;
    end
  end

  iddr_deser_fifo #(
    .W     (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_data  (word),
    .i_pop   (i_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_drop  (drop)
  );

  assign o_locked    = (st_q == ST_LOCKED);
  assign o_align_err = err_q;
  assign o_overflow  = ovf_q;

endmodule
